// File: rtl/usb_dfu_flash_sequencer_if.sv
// Bridge-side bundle of the DFU flash sequencer: sector/offset addressing,
// request lines and per-byte strobes towards the SPI flash bridge.
interface usb_dfu_flash_sequencer_if #(
    parameter int unsigned OFFSET_W = 12
) ();
    logic [15:0]         flash_address;
    logic [OFFSET_W-1:0] flash_offset;
    logic                flash_busy;
    logic                flash_rd_request;
    logic                flash_rd_data_free;
    logic                flash_rd_data_put;
    logic                flash_wr_request;
    logic                flash_wr_data_get;

    modport master (
        output flash_address,
        output flash_offset,
        output flash_rd_request,
        output flash_rd_data_free,
        output flash_wr_request,
        input  flash_busy,
        input  flash_rd_data_put,
        input  flash_wr_data_get
    );

    modport slave (
        input  flash_address,
        input  flash_offset,
        input  flash_rd_request,
        input  flash_rd_data_free,
        input  flash_wr_request,
        output flash_busy,
        output flash_rd_data_put,
        output flash_wr_data_get
    );
endinterface

// File: rtl/usb_dfu_flash_sequencer.sv
// Turns DFU DNLOAD/UPLOAD block requests into SPI flash bridge operations:
// erase on sector start, page-write streaming and offset-skipping reads.
module usb_dfu_flash_sequencer #(
    parameter int unsigned SECTOR_SIZE = 4096,
    parameter int unsigned BLOCK_SIZE  = 256,
    parameter int unsigned BASE_SECTOR = 16,
    parameter int unsigned NUM_SECTORS = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_dnload,
    input  logic        cmd_upload,
    input  logic [15:0] cmd_block,
    input  logic [15:0] cmd_length,
    output logic        cmd_ready,
    output logic        cmd_done,
    output logic        cmd_error,
    input  logic        up_data_free,
    output logic        up_data_put,
    output logic        dn_data_get,
    usb_dfu_flash_sequencer_if.master flash
);
    localparam int unsigned OFF_W  = $clog2(SECTOR_SIZE);
    localparam int unsigned BLK_SH = $clog2(BLOCK_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        ERASE_REQ,
        ERASE_WAIT,
        WRITE_REQ,
        WRITE_DATA,
        READ_DATA,
        DONE,
        ERROR
    } state_t;

    state_t             state, state_next;
    logic [15:0]        addr_q;
    logic [OFF_W-1:0]   off_q;
    logic [15:0]        len_q;
    logic [15:0]        xfer_cnt;
    logic [15:0]        skip_cnt;
    logic               xfer_inc;
    logic               skip_inc;

    logic [31:0]        byte_addr;
    logic [31:0]        sector_idx;
    logic [OFF_W-1:0]   cmd_offset;
    logic               range_err;
    logic               len_err;
    logic               start;

    // Sector/offset split is a pure shift and mask of the 32-bit byte address.
    assign byte_addr  = {16'h0000, cmd_block} << BLK_SH;
    assign sector_idx = byte_addr >> OFF_W;
    assign cmd_offset = byte_addr[OFF_W-1:0];
    assign range_err  = sector_idx >= NUM_SECTORS;
    assign len_err    = cmd_length > 16'(BLOCK_SIZE);
    assign start      = cmd_dnload | cmd_upload;

    assign flash.flash_address = addr_q;
    assign flash.flash_offset  = off_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            addr_q   <= '0;
            off_q    <= '0;
            len_q    <= '0;
            xfer_cnt <= '0;
            skip_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                xfer_cnt <= '0;
                skip_cnt <= '0;
                if (start) begin
                    addr_q <= 16'(BASE_SECTOR + sector_idx);
                    off_q  <= cmd_offset;
                    len_q  <= cmd_length;
                end
            end else begin
                if (xfer_inc) xfer_cnt <= xfer_cnt + 16'd1;
                if (skip_inc) skip_cnt <= skip_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        state_next               = state;
        cmd_ready                = 1'b0;
        cmd_done                 = 1'b0;
        cmd_error                = 1'b0;
        up_data_put              = 1'b0;
        dn_data_get              = 1'b0;
        xfer_inc                 = 1'b0;
        skip_inc                 = 1'b0;
        flash.flash_rd_request   = 1'b0;
        flash.flash_rd_data_free = 1'b0;
        flash.flash_wr_request   = 1'b0;

        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (start) begin
                    if (range_err || len_err)  state_next = ERROR;
                    else if (cmd_length == '0) state_next = DONE;
                    else if (cmd_dnload)       state_next = (cmd_offset == '0) ? ERASE_REQ : WRITE_REQ;
                    else                       state_next = READ_DATA;
                end
            end
            ERASE_REQ: begin
                flash.flash_wr_request = 1'b1;
                if (flash.flash_busy) state_next = ERASE_WAIT;
            end
            ERASE_WAIT: begin
                if (!flash.flash_busy) state_next = WRITE_REQ;
            end
            WRITE_REQ, WRITE_DATA: begin
                // Request is live only until the terminal count, so a strobe
                // arriving after the last byte is never forwarded.
                if (xfer_cnt != len_q) begin
                    flash.flash_wr_request = 1'b1;
                    dn_data_get            = flash.flash_wr_data_get;
                    xfer_inc               = flash.flash_wr_data_get;
                end
                if (state == WRITE_REQ)
                    state_next = WRITE_DATA;
                else if (xfer_cnt == len_q && !flash.flash_busy)
                    state_next = DONE;
            end
            READ_DATA: begin
                if (xfer_cnt != len_q) begin
                    flash.flash_rd_request = 1'b1;
                    if (skip_cnt != 16'(off_q)) begin
                        flash.flash_rd_data_free = 1'b1;
                        skip_inc                 = flash.flash_rd_data_put;
                    end else begin
                        flash.flash_rd_data_free = up_data_free;
                        up_data_put              = flash.flash_rd_data_put & up_data_free;
                        xfer_inc                 = up_data_put;
                    end
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                cmd_done   = 1'b1;
                state_next = IDLE;
            end
            ERROR: begin
                cmd_error  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_usb_dfu_flash_sequencer.sv
// Directed self-checking bench for usb_dfu_flash_sequencer; the bridge and
// upstream sides are driven step by step from a single initial block.
module tb_usb_dfu_flash_sequencer;
    logic        clk;
    logic        reset;
    logic        cmd_dnload;
    logic        cmd_upload;
    logic [15:0] cmd_block;
    logic [15:0] cmd_length;
    logic        cmd_ready;
    logic        cmd_done;
    logic        cmd_error;
    logic        up_data_free;
    logic        up_data_put;
    logic        dn_data_get;

    int checks = 0;
    int passes = 0;

    usb_dfu_flash_sequencer_if #(.OFFSET_W(12)) flash_bus ();

    usb_dfu_flash_sequencer #(
        .SECTOR_SIZE(4096),
        .BLOCK_SIZE (256),
        .BASE_SECTOR(16),
        .NUM_SECTORS(240)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_dnload  (cmd_dnload),
        .cmd_upload  (cmd_upload),
        .cmd_block   (cmd_block),
        .cmd_length  (cmd_length),
        .cmd_ready   (cmd_ready),
        .cmd_done    (cmd_done),
        .cmd_error   (cmd_error),
        .up_data_free(up_data_free),
        .up_data_put (up_data_put),
        .dn_data_get (dn_data_get),
        .flash       (flash_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic pulse_cmd(input logic dn, input logic up, input logic [15:0] blk, input logic [15:0] len);
        cmd_dnload = dn;
        cmd_upload = up;
        cmd_block  = blk;
        cmd_length = len;
        tick();
        cmd_dnload = 1'b0;
        cmd_upload = 1'b0;
        #1;
    endtask

    // Streams write strobes every cycle until the request drops, then checks
    // the completion pulse lands exactly one cycle after the exit condition.
    task automatic finish_write(input string tag, input int exp_gets, input logic busy_during);
        int gets  = 0;
        int guard = 0;
        flash_bus.flash_busy        = busy_during;
        flash_bus.flash_wr_data_get = 1'b1;
        #1;
        while (flash_bus.flash_wr_request && guard < 1000) begin
            gets += int'(dn_data_get);
            guard++;
            tick();
        end
        flash_bus.flash_wr_data_get = 1'b0;
        #1;
        chk({tag, "_gets"}, 32'(gets), 32'(exp_gets));
        chk({tag, "_req_drop"}, 32'(flash_bus.flash_wr_request), 32'd0);
        if (busy_during) begin
            tick();
            tick();
            chk({tag, "_done_held_by_busy"}, 32'(cmd_done), 32'd0);
            flash_bus.flash_busy = 1'b0;
            #1;
        end
        chk({tag, "_done_early"}, 32'(cmd_done), 32'd0);
        tick();
        chk({tag, "_done"}, 32'(cmd_done), 32'd1);
        tick();
        chk({tag, "_done_single"}, 32'(cmd_done), 32'd0);
        chk({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int bridge_bytes;
        int fwd;
        int viol;
        int first_fwd;
        int guard;
        int gets;
        int done_seen;
        logic toggle;

        reset        = 1'b1;
        cmd_dnload   = 1'b0;
        cmd_upload   = 1'b0;
        cmd_block    = '0;
        cmd_length   = '0;
        up_data_free = 1'b0;
        flash_bus.flash_busy        = 1'b0;
        flash_bus.flash_rd_data_put = 1'b0;
        flash_bus.flash_wr_data_get = 1'b0;
        tick();
        tick();
        chk("rst_ready",  32'(cmd_ready), 32'd1);
        chk("rst_wr_req", 32'(flash_bus.flash_wr_request), 32'd0);
        chk("rst_rd_req", 32'(flash_bus.flash_rd_request), 32'd0);
        chk("rst_addr",   32'(flash_bus.flash_address), 32'd0);
        chk("rst_offset", 32'(flash_bus.flash_offset), 32'd0);
        chk("rst_done",   32'(cmd_done), 32'd0);
        chk("rst_error",  32'(cmd_error), 32'd0);
        reset = 1'b0;
        tick();

        // Download block 0, full block: erase first.
        pulse_cmd(1'b1, 1'b0, 16'd0, 16'd256);
        chk("dl0_ready_low", 32'(cmd_ready), 32'd0);
        chk("dl0_addr",      32'(flash_bus.flash_address), 32'd16);
        chk("dl0_erase_req", 32'(flash_bus.flash_wr_request), 32'd1);
        chk("dl0_erase_off", 32'(flash_bus.flash_offset), 32'd0);
        tick();
        chk("dl0_erase_hold", 32'(flash_bus.flash_wr_request), 32'd1);
        flash_bus.flash_busy = 1'b1;
        tick();
        chk("dl0_erase_drop", 32'(flash_bus.flash_wr_request), 32'd0);
        tick();
        tick();
        chk("dl0_erase_wait", 32'(flash_bus.flash_wr_request), 32'd0);
        flash_bus.flash_busy = 1'b0;
        tick();
        chk("dl0_write_req", 32'(flash_bus.flash_wr_request), 32'd1);
        chk("dl0_write_off", 32'(flash_bus.flash_offset), 32'd0);
        finish_write("dl0", 256, 1'b1);

        // Download block 5, 100 bytes: mid-sector, no erase.
        pulse_cmd(1'b1, 1'b0, 16'd5, 16'd100);
        chk("dl5_addr",   32'(flash_bus.flash_address), 32'd16);
        chk("dl5_offset", 32'(flash_bus.flash_offset), 32'h500);
        flash_bus.flash_wr_data_get = 1'b1;
        #1;
        chk("dl5_no_erase", 32'(dn_data_get), 32'd1);
        finish_write("dl5", 100, 1'b0);

        // Upload block 1: skip 256 bridge bytes, forward the next 256.
        pulse_cmd(1'b0, 1'b1, 16'd1, 16'd256);
        chk("ul1_addr",     32'(flash_bus.flash_address), 32'd16);
        chk("ul1_rd_req",   32'(flash_bus.flash_rd_request), 32'd1);
        chk("ul1_skip_free", 32'(flash_bus.flash_rd_data_free), 32'd1);
        bridge_bytes = 0;
        fwd          = 0;
        viol         = 0;
        first_fwd    = -1;
        guard        = 0;
        toggle       = 1'b0;
        while (flash_bus.flash_rd_request && guard < 2000) begin
            toggle       = ~toggle;
            up_data_free = toggle;
            flash_bus.flash_rd_data_put = 1'b0;
            #1;
            flash_bus.flash_rd_data_put = flash_bus.flash_rd_data_free;
            #1;
            if (up_data_put && first_fwd < 0) first_fwd = bridge_bytes;
            bridge_bytes += int'(flash_bus.flash_rd_data_put);
            fwd          += int'(up_data_put);
            viol         += int'(up_data_put && !up_data_free);
            guard++;
            tick();
        end
        flash_bus.flash_rd_data_put = 1'b0;
        up_data_free                = 1'b0;
        #1;
        chk("ul1_bridge_bytes", 32'(bridge_bytes), 32'd512);
        chk("ul1_forwarded",    32'(fwd), 32'd256);
        chk("ul1_first_fwd",    32'(first_fwd), 32'd256);
        chk("ul1_put_not_free", 32'(viol), 32'd0);
        chk("ul1_req_drop",     32'(flash_bus.flash_rd_request), 32'd0);
        chk("ul1_done_early",   32'(cmd_done), 32'd0);
        tick();
        chk("ul1_done", 32'(cmd_done), 32'd1);
        tick();
        chk("ul1_ready_back", 32'(cmd_ready), 32'd1);

        // Sector out of range.
        pulse_cmd(1'b1, 1'b0, 16'd3840, 16'd16);
        chk("rng_error",  32'(cmd_error), 32'd1);
        chk("rng_ready",  32'(cmd_ready), 32'd0);
        chk("rng_wr_req", 32'(flash_bus.flash_wr_request), 32'd0);
        chk("rng_rd_req", 32'(flash_bus.flash_rd_request), 32'd0);
        tick();
        chk("rng_error_single", 32'(cmd_error), 32'd0);
        chk("rng_ready_back",   32'(cmd_ready), 32'd1);

        // Last valid block: sector 239, offset 0xF00.
        pulse_cmd(1'b1, 1'b0, 16'd3839, 16'd1);
        chk("last_error",  32'(cmd_error), 32'd0);
        chk("last_addr",   32'(flash_bus.flash_address), 32'd255);
        chk("last_offset", 32'(flash_bus.flash_offset), 32'hF00);
        finish_write("last", 1, 1'b0);

        // Oversized length.
        pulse_cmd(1'b0, 1'b1, 16'd0, 16'd300);
        chk("len_error",  32'(cmd_error), 32'd1);
        chk("len_rd_req", 32'(flash_bus.flash_rd_request), 32'd0);
        tick();
        chk("len_error_single", 32'(cmd_error), 32'd0);

        // Reset mid-write after 50 bytes.
        pulse_cmd(1'b1, 1'b0, 16'd2, 16'd200);
        chk("mid_offset", 32'(flash_bus.flash_offset), 32'h200);
        flash_bus.flash_wr_data_get = 1'b1;
        #1;
        gets = 0;
        repeat (50) begin
            gets += int'(dn_data_get);
            tick();
        end
        chk("mid_gets",   32'(gets), 32'd50);
        chk("mid_req_on", 32'(flash_bus.flash_wr_request), 32'd1);
        reset                       = 1'b1;
        flash_bus.flash_wr_data_get = 1'b0;
        tick();
        chk("mid_req_off", 32'(flash_bus.flash_wr_request), 32'd0);
        chk("mid_ready",   32'(cmd_ready), 32'd1);
        chk("mid_addr",    32'(flash_bus.flash_address), 32'd0);
        done_seen = int'(cmd_done);
        reset     = 1'b0;
        repeat (3) begin
            tick();
            done_seen += int'(cmd_done);
        end
        chk("mid_no_done", 32'(done_seen), 32'd0);

        // Simultaneous pulses: download path wins.
        pulse_cmd(1'b1, 1'b1, 16'd0, 16'd16);
        chk("both_wr_req", 32'(flash_bus.flash_wr_request), 32'd1);
        chk("both_rd_req", 32'(flash_bus.flash_rd_request), 32'd0);
        flash_bus.flash_busy = 1'b1;
        tick();
        flash_bus.flash_busy = 1'b0;
        tick();
        finish_write("both", 16, 1'b0);

        // Zero length: immediate completion, no bridge activity.
        pulse_cmd(1'b1, 1'b0, 16'd4, 16'd0);
        chk("zero_done",   32'(cmd_done), 32'd1);
        chk("zero_wr_req", 32'(flash_bus.flash_wr_request), 32'd0);
        tick();
        chk("zero_done_single", 32'(cmd_done), 32'd0);
        chk("zero_ready",       32'(cmd_ready), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/usb_dfu_flash_sequencer.md
# usb_dfu_flash_sequencer

Command sequencer between the USB DFU class logic and the SPI flash bridge. Turns DFU DNLOAD/UPLOAD block requests into bridge operations: sector address computation, erase on the first block of each sector, page-write streaming, and offset-skipping reads. It is the only block that drives the bridge's address and request lines, and it reports completion and range errors back to the DFU state machine.

## Interface
- SECTOR_SIZE, 4096: erase granularity in bytes; power of two; multiple of BLOCK_SIZE.
- BLOCK_SIZE, 256: DFU transfer size in bytes; power of two, at least 16.
- BASE_SECTOR, 16: first flash sector of the user image; DFU block 0 maps here.
- NUM_SECTORS, 240: sectors available to the image.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- cmd_dnload  in  1  one-cycle pulse; start a download block.
- cmd_upload  in  1  one-cycle pulse; start an upload block.
- cmd_block  in  16  DFU block number; sampled on the start pulse.
- cmd_length  in  16  payload bytes; sampled on the start pulse.
- cmd_ready  out  1  high only in IDLE.
- cmd_done  out  1  one-cycle pulse on successful completion.
- cmd_error  out  1  one-cycle pulse on a rejected command.
- up_data_free  in  1  upstream can accept an upload byte.
- up_data_put  out  1  an upload byte is valid on flash_rd_data this cycle.
- dn_data_get  out  1  a download byte is consumed this cycle; mirrors flash_wr_data_get during WRITE.
- flash_address  out  16  sector number to the bridge.
- flash_offset  out  log2(SECTOR_SIZE)  byte offset within the sector for page writes.
- flash_busy  in  1  bridge busy.
- flash_rd_request  out  1  read request.
- flash_rd_data_free  out  1  read-side flow control to the bridge.
- flash_rd_data_put  in  1  bridge read byte strobe.
- flash_wr_request  out  1  write request.
- flash_wr_data_get  in  1  bridge write byte strobe.

## Operation
- Byte address = cmd_block × BLOCK_SIZE, computed in 32 bits.
- sector = BASE_SECTOR + byte_addr / SECTOR_SIZE.
- offset = byte_addr mod SECTOR_SIZE.
- Both use shifts and masks only; a constant divider is not allowed.
- Error (→ ERROR) when byte_addr / SECTOR_SIZE ≥ NUM_SECTORS, or when cmd_length > BLOCK_SIZE.
- cmd_length == 0 → DONE with no bridge activity. This is the DFU manifest/EOF case.
- States: IDLE, ERASE_REQ, ERASE_WAIT, WRITE_REQ, WRITE_DATA, READ_DATA, DONE, ERROR.
- IDLE transitions:
  - cmd_dnload with offset == 0 → ERASE_REQ.
  - cmd_dnload with offset ≠ 0 → WRITE_REQ.
  - cmd_upload → READ_DATA.
  - If both pulses arrive in the same cycle, dnload wins and upload is ignored.
- ERASE_REQ: hold flash_wr_request with flash_offset = 0 until flash_busy is sampled high, then drop the request → ERASE_WAIT.
- ERASE_WAIT: on flash_busy low → WRITE_REQ.
- WRITE_REQ/WRITE_DATA:
  - Present flash_offset = offset and assert flash_wr_request.
  - Count flash_wr_data_get; at count == cmd_length, drop the request.
  - Wait for flash_busy low → DONE.
- READ_DATA:
  - Assert flash_rd_request.
  - Skip phase: the first `offset` bytes from the bridge are discarded. flash_rd_data_free = 1 and up_data_put = 0.
  - Payload phase: flash_rd_data_free = up_data_free and up_data_put = flash_rd_data_put.
  - After cmd_length payload puts, drop the request → DONE.
- DONE pulses cmd_done and ERROR pulses cmd_error; both return to IDLE on the next cycle.
- Start pulses outside IDLE are ignored. No queueing.

## Timing
- Reset values:
  - cmd_ready = 1.
  - flash_address = 0 and flash_offset = 0.
  - All pulse, request and put outputs = 0.
  - State = IDLE; counters = 0.
- A reset asserted mid-operation drops every request on the following edge, with no completion pulse.
- Start pulse at edge N:
  - cmd_ready = 0 from N+1.
  - flash_address/flash_offset valid from N+1 and held stable until IDLE.
  - The first request asserts at N+1.
  - An error pulses cmd_error at N+1, and cmd_ready returns at N+2.
- Byte counters are 16-bit. The skip counter compares against the registered offset, and the payload counter against the registered length.
- A put and the last-byte terminal count in the same cycle: the request deasserts on the next edge, and no extra byte is forwarded.
- cmd_done is asserted exactly one cycle after the exit condition, then cmd_ready = 1.

## Test plan
- Reset with all inputs low → cmd_ready = 1; flash_*_request = 0; flash_address = 0.
- Download block 0, length 256 (BLOCK 256, SECTOR 4096, BASE 16) → flash_address = 16 and erase request; after busy high then low, write request with flash_offset = 0; exactly 256 dn_data_get; then one cmd_done pulse.
- Download block 5, length 100 → no erase; flash_address = 16, flash_offset = 0x500; 100 gets, then cmd_done.
- Upload block 1, length 256, with up_data_free toggling → the first 256 bridge bytes are discarded and the next 256 are forwarded; up_data_put never fires while up_data_free is low.
- Download block 3840 (sector 240 ≥ NUM_SECTORS), and separately a length of 300 → a single cmd_error pulse each, with no bridge request.
- Reset asserted mid-write after 50 gets → requests low on the next edge, no cmd_done, cmd_ready = 1. Also: simultaneous dnload + upload → download path; length 0 → immediate cmd_done.
